sha_2_msg_padder: RTL and testbench

//  Producer side of the SHA-2 engine data_in valid/ready interface. It takes a message length
//  and then a stream of 32-bit message words. It packs them into 512-bit blocks and appends
//  SHA-2 padding: a 0x80000000 marker word, zero fill, and a 64-bit bit-length.
//  It sits between the host word bus and sha_2_engine.data_in, and never loses or reorders words.

---
 rtl/sha_2_msg_padder.sv | 155 +++++++++++++++
 tb/tb_sha_2_msg_padder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sha_2_msg_padder.sv
// SHA-2 message padder: packs 32-bit words into 512-bit blocks, appends the 0x80 marker,
// zero fill and 64-bit bit-length, and hands blocks to the engine over valid/ready.
module sha_2_msg_padder #(
    parameter int unsigned LEN_W = 64
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [LEN_W-1:0] cfg_size,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [31:0]      word_in,
    input  logic             word_in_valid,
    output logic             word_in_ready,
    output logic [511:0]     data_out,
    output logic             data_out_valid,
    input  logic             data_out_ready,
    output logic             data_out_last
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned N_WORDS = 16;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned LEN_FW  = 64;
    localparam int unsigned WL_W    = 59;
    localparam logic [WORD_W-1:0] MARKER = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PAD,
        S_EMIT
    } state_t;

    state_t                               state_q, state_d;
    logic [0:N_WORDS-1][WORD_W-1:0]       blk_q, blk_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [WL_W-1:0]                      words_left_q, words_left_d;
    logic [LEN_FW-1:0]                    len_q, len_d;
    logic                                 pad_placed_q, pad_placed_d;
    logic                                 final_blk_q, final_blk_d;
    logic                                 cfg_ready_q, word_in_ready_q, data_out_valid_q;

    // Low five size bits are ignored: messages are word granular.
    logic unused_size_lsbs;
    assign unused_size_lsbs = ^cfg_size[4:0];

    // State register and registered handshake outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q          <= S_IDLE;
            blk_q            <= '0;
            idx_q            <= '0;
            words_left_q     <= '0;
            len_q            <= '0;
            pad_placed_q     <= 1'b0;
            final_blk_q      <= 1'b0;
            cfg_ready_q      <= 1'b1;
            word_in_ready_q  <= 1'b0;
            data_out_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            blk_q            <= blk_d;
            idx_q            <= idx_d;
            words_left_q     <= words_left_d;
            len_q            <= len_d;
            pad_placed_q     <= pad_placed_d;
            final_blk_q      <= final_blk_d;
            cfg_ready_q      <= (state_d == S_IDLE);
            word_in_ready_q  <= (state_d == S_LOAD);
            data_out_valid_q <= (state_d == S_EMIT);
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d      = state_q;
        blk_d        = blk_q;
        idx_d        = idx_q;
        words_left_d = words_left_q;
        len_d        = len_q;
        pad_placed_d = pad_placed_q;
        final_blk_d  = final_blk_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid && cfg_ready_q) begin
                    len_d        = LEN_FW'({cfg_size[LEN_W-1:5], 5'b0});
                    words_left_d = len_d[LEN_FW-1:5];
                    idx_d        = '0;
                    pad_placed_d = 1'b0;
                    final_blk_d  = 1'b0;
                    state_d      = (words_left_d == '0) ? S_PAD : S_LOAD;
                end
            end
            S_LOAD: begin
                if (word_in_valid && word_in_ready_q) begin
                    blk_d[idx_q[3:0]] = word_in;
                    idx_d             = idx_q + IDX_W'(1);
                    words_left_d      = words_left_q - WL_W'(1);
                    if (idx_d == IDX_W'(N_WORDS)) begin
                        state_d     = S_EMIT;
                        final_blk_d = 1'b0;
                    end else if (words_left_d == '0) begin
                        state_d = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (!pad_placed_q) begin
                    blk_d[idx_q[3:0]] = MARKER;
                    for (int unsigned i = 0; i < N_WORDS; i++) begin
                        if (i > 32'(idx_q)) blk_d[4'(i)] = '0;
                    end
                    if (idx_q <= IDX_W'(13)) begin
                        blk_d[14]   = len_q[63:32];
                        blk_d[15]   = len_q[31:0];
                        final_blk_d = 1'b1;
                    end else begin
                        pad_placed_d = 1'b1;
                        final_blk_d  = 1'b0;
                    end
                end else begin
                    // Marker already went out in the previous block: length-only block.
                    for (int unsigned i = 0; i < 14; i++) blk_d[4'(i)] = '0;
                    blk_d[14]   = len_q[63:32];
                    blk_d[15]   = len_q[31:0];
                    final_blk_d = 1'b1;
                end
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (data_out_valid_q && data_out_ready) begin
                    blk_d = '0;
                    idx_d = '0;
                    if (final_blk_q) begin
                        final_blk_d = 1'b0;
                        state_d     = S_IDLE;
                    end else if (words_left_q != '0) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_PAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cfg_ready      = cfg_ready_q;
    assign word_in_ready  = word_in_ready_q;
    assign data_out_valid = data_out_valid_q;
    assign data_out       = blk_q;
    assign data_out_last  = final_blk_q;

endmodule

// File: tb/tb_sha_2_msg_padder.sv
// Directed table-driven bench for sha_2_msg_padder: hand-built expected blocks per message size.
module tb_sha_2_msg_padder;

    logic         clk = 1'b0;
    logic         nrst;
    logic [63:0]  cfg_size;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [31:0]  word_in;
    logic         word_in_valid;
    logic         word_in_ready;
    logic [511:0] data_out;
    logic         data_out_valid;
    logic         data_out_ready;
    logic         data_out_last;

    int n_tests = 0;
    int n_fail  = 0;

    sha_2_msg_padder #(.LEN_W(64)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .cfg_size      (cfg_size),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .word_in       (word_in),
        .word_in_valid (word_in_valid),
        .word_in_ready (word_in_ready),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .data_out_last (data_out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]               size;
        int                        nwords;
        int                        nblk;
        int                        lat;
        int                        stall;
        logic [1:0]                last;
        logic [0:1][0:15][31:0]    blk;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [31:0] dw(input int i);
        return (i == 0) ? 32'h6162_6364 : 32'h1000_0000 + 32'(i);
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_cfg(input logic [63:0] sz);
        int cnt = 0;
        cfg_size  = sz;
        cfg_valid = 1'b1;
        while (!cfg_ready && cnt < 50) begin
            @(posedge clk); #1; cnt++;
        end
        chk("cfg_accept_timeout", 512'(cnt < 50), 512'(1));
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int cnt = 0;
        word_in       = w;
        word_in_valid = 1'b1;
        while (!word_in_ready && cnt < 50) begin
            @(posedge clk); #1; cnt++;
        end
        if (cnt >= 50) chk("word_accept_timeout", 512'(0), 512'(1));
        @(posedge clk); #1;
        word_in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [511:0] snap;
        logic         stable;
        int           cnt;
        send_cfg(v.size);
        if (v.nwords > 0) begin
            chk($sformatf("v%0d_cfg_ready_in_load", id), 512'(cfg_ready), 512'(0));
            chk($sformatf("v%0d_word_ready_in_load", id), 512'(word_in_ready), 512'(1));
        end
        for (int w = 0; w < v.nwords; w++) send_word(dw(w));
        for (int b = 0; b < v.nblk; b++) begin
            cnt = 0;
            while (!data_out_valid && cnt < 50) begin
                @(posedge clk); #1; cnt++;
            end
            chk($sformatf("v%0d_b%0d_valid", id, b), 512'(data_out_valid), 512'(1));
            if (b == 0) chk($sformatf("v%0d_latency", id), 512'(cnt), 512'(v.lat));
            if (v.stall > 0 && b == 0) begin
                snap   = data_out;
                stable = 1'b1;
                repeat (v.stall) begin
                    @(posedge clk); #1;
                    if (data_out !== snap || !data_out_valid || word_in_ready) stable = 1'b0;
                end
                chk($sformatf("v%0d_hold_stable", id), 512'(stable), 512'(1));
            end
            chk($sformatf("v%0d_b%0d_data", id, b), data_out, 512'(v.blk[b]));
            chk($sformatf("v%0d_b%0d_last", id, b), 512'(data_out_last), 512'(v.last[b]));
            data_out_ready = 1'b1;
            @(posedge clk); #1;
            data_out_ready = 1'b0;
        end
        chk($sformatf("v%0d_cfg_ready_after", id), 512'(cfg_ready), 512'(1));
        chk($sformatf("v%0d_valid_after", id), 512'(data_out_valid), 512'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cfg_ready"}, 512'(cfg_ready), 512'(1));
        chk({tag, "_word_ready"}, 512'(word_in_ready), 512'(0));
        chk({tag, "_valid"}, 512'(data_out_valid), 512'(0));
        chk({tag, "_last"}, 512'(data_out_last), 512'(0));
        chk({tag, "_data"}, data_out, 512'(0));
    endtask

    initial begin
        for (int v = 0; v < 7; v++) begin
            vecs[v].blk   = '0;
            vecs[v].stall = 0;
            vecs[v].lat   = 1;
            vecs[v].nblk  = 1;
            vecs[v].last  = 2'b01;
        end
        // empty message
        vecs[0].size = 64'd0;   vecs[0].nwords = 0;
        vecs[0].blk[0][0] = 32'h8000_0000;
        // one word "abcd"
        vecs[1].size = 64'd32;  vecs[1].nwords = 1;
        vecs[1].blk[0][0] = 32'h6162_6364; vecs[1].blk[0][1] = 32'h8000_0000;
        vecs[1].blk[0][15] = 32'h20;
        // 13 words: marker and length fit
        vecs[2].size = 64'd416; vecs[2].nwords = 13;
        for (int k = 0; k < 13; k++) vecs[2].blk[0][k] = dw(k);
        vecs[2].blk[0][13] = 32'h8000_0000; vecs[2].blk[0][15] = 32'h1A0;
        // 14 words: marker in word14, length spills
        vecs[3].size = 64'd448; vecs[3].nwords = 14; vecs[3].nblk = 2; vecs[3].last = 2'b10;
        for (int k = 0; k < 14; k++) vecs[3].blk[0][k] = dw(k);
        vecs[3].blk[0][14] = 32'h8000_0000; vecs[3].blk[1][15] = 32'h1C0;
        // 16 words with back-pressure
        vecs[4].size = 64'd512; vecs[4].nwords = 16; vecs[4].nblk = 2; vecs[4].last = 2'b10;
        vecs[4].lat = 0; vecs[4].stall = 10;
        for (int k = 0; k < 16; k++) vecs[4].blk[0][k] = dw(k);
        vecs[4].blk[1][0] = 32'h8000_0000; vecs[4].blk[1][15] = 32'h200;
        // 15 words: marker in word15
        vecs[5].size = 64'd480; vecs[5].nwords = 15; vecs[5].nblk = 2; vecs[5].last = 2'b10;
        for (int k = 0; k < 15; k++) vecs[5].blk[0][k] = dw(k);
        vecs[5].blk[0][15] = 32'h8000_0000; vecs[5].blk[1][15] = 32'h1E0;
        // sub-word size bits ignored
        vecs[6] = vecs[1];
        vecs[6].size = 64'd33;

        nrst = 1'b0; cfg_size = '0; cfg_valid = 1'b0; word_in = '0;
        word_in_valid = 1'b0; data_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        nrst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

        // reset mid-message discards partial state
        send_cfg(64'd512);
        for (int w = 0; w < 5; w++) send_word(dw(w));
        nrst = 1'b0;
        #3;
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[1], 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
